// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default widths, the HALT opcode and the jump-target table contents.
package instr_fetch_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int IW_DEF        = 9;
  localparam int MCODEBITS_DEF = 4;
  localparam int LUT_W_DEF     = 5;

  localparam logic [MCODEBITS_DEF-1:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Entry i holds i*20, except the last two, which point at the top of memory.
  localparam int JUMP_TABLE_DEPTH = 32;
  localparam int unsigned JUMP_TABLE [JUMP_TABLE_DEPTH] = '{
      0,  20,  40,  60,  80, 100, 120, 140,
    160, 180, 200, 220, 240, 260, 280, 300,
    320, 340, 360, 380, 400, 420, 440, 460,
    480, 500, 520, 540, 560, 580, 1000, 1023
  };

endpackage

// File: rtl/instr_fetch_jump_lut.sv
// Combinational jump-target table: LUT index from the instruction word to a
// program-counter target.
module jump_lut
  import instr_fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  localparam int DEPTH = 1 << LUT_W;

  logic [PC_W-1:0] lut_mem [DEPTH];

  // Entries beyond the package table (when LUT_W is enlarged) read as zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (i < JUMP_TABLE_DEPTH) begin : g_init
      assign lut_mem[i] = PC_W'(JUMP_TABLE[i]);
    end else begin : g_zero
      assign lut_mem[i] = '0;
    end
  end

  assign target = lut_mem[idx];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter and IDLE/RUN/HALT sequencing with
// jumps, conditional branches, stall and end-of-memory overflow detection.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int IW        = IW_DEF,
  parameter int MCODEBITS = MCODEBITS_DEF,
  parameter int LUT_W     = LUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 cond_true,
  input  logic                 UncondJump,
  input  logic                 JType,
  input  logic [IW-1:0]        imem_data,
  output logic [PC_W-1:0]      imem_addr,
  output logic [MCODEBITS-1:0] instr,
  output logic                 valid,
  output logic                 done,
  output logic                 pc_ovf
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_ovf_q, pc_ovf_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] jump_target;
  logic            is_halt_op;
  logic            take_jump;

  assign instr = imem_data[IW-1 -: MCODEBITS];

  jump_lut #(
    .PC_W (PC_W),
    .LUT_W(LUT_W)
  ) u_jump_lut (
    .idx   (imem_data[LUT_W-1:0]),
    .target(jump_target)
  );

  assign is_halt_op = (instr == MCODEBITS'(HALT_OPCODE));
  assign take_jump  = UncondJump || (JType && cond_true);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_ovf_d = pc_ovf_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (is_halt_op) begin
            state_d = ST_HALT;
          end else if (take_jump) begin
            pc_d = jump_target;
          end else if (&pc_q) begin
            // Incrementing past the last word would wrap; stop instead.
            state_d  = ST_HALT;
            pc_ovf_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          pc_ovf_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pc_d     = '0;
        pc_ovf_d = 1'b0;
      end
    endcase
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      pc_ovf_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_ovf_q <= pc_ovf_d;
      done_q   <= done_d;
    end
  end

  assign imem_addr = pc_q;
  assign valid     = (state_q == ST_RUN) && !stall;
  assign done      = done_q;
  assign pc_ovf    = pc_ovf_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: the bench supplies instruction memory
// and a tiny opcode decoder (8 = unconditional jump, 9 = conditional jump).
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       cond_true;
  logic       uncond_jump;
  logic       jtype;
  logic [8:0] imem_data;
  logic [9:0] imem_addr;
  logic [3:0] instr;
  logic       valid;
  logic       done;
  logic       pc_ovf;

  logic [8:0] mem [1024];

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] NOP = {4'h1, 5'd0};

  instr_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .cond_true (cond_true),
    .UncondJump(uncond_jump),
    .JType     (jtype),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .instr     (instr),
    .valid     (valid),
    .done      (done),
    .pc_ovf    (pc_ovf)
  );

  assign imem_data   = mem[imem_addr];
  assign uncond_jump = (instr == 4'h8);
  assign jtype       = (instr == 4'h9);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // All tasks start and end just after a falling edge.
  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    cond_true = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    checks++;
    if ({imem_addr, valid, done, pc_ovf} !== {10'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_state: addr=%0d v=%b d=%b o=%b, expected addr=0 v=0 d=0 o=0",
               imem_addr, valid, done, pc_ovf);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_addr, valid} !== {10'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL idle_hold: addr=%0d v=%b, expected addr=0 v=0", imem_addr, valid);
    end
  endtask

  task automatic test_sequential();
    fill_mem();
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({imem_addr, valid} !== {10'(i), 1'b1}) begin
        errors++;
        $display("[TB] FAIL seq_addr%0d: addr=%0d v=%b, expected addr=%0d v=1", i, imem_addr, valid, i);
      end
      @(negedge clk);
    end
    // PC is 5 here; start while running must not restart at 0.
    do_start();
    checks++;
    if (imem_addr !== 10'd6) begin
      errors++;
      $display("[TB] FAIL start_in_run: addr=%0d, expected 6", imem_addr);
    end
  endtask

  task automatic test_uncond_jump();
    fill_mem();
    mem[3] = {4'h8, 5'd2};
    do_reset();
    do_start();
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_addr, instr} !== {10'd3, 4'h8}) begin
      errors++;
      $display("[TB] FAIL ujump_at3: addr=%0d instr=%h, expected addr=3 instr=8", imem_addr, instr);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd40) begin
      errors++;
      $display("[TB] FAIL ujump_target: addr=%0d, expected 40", imem_addr);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd41) begin
      errors++;
      $display("[TB] FAIL ujump_after: addr=%0d, expected 41", imem_addr);
    end
  endtask

  task automatic test_cond_jump();
    for (int pass = 0; pass < 2; pass++) begin
      fill_mem();
      mem[7] = {4'h9, 5'd1};
      do_reset();
      cond_true = (pass == 1);
      do_start();
      repeat (7) @(negedge clk);
      checks++;
      if (imem_addr !== 10'd7) begin
        errors++;
        $display("[TB] FAIL cjump_at7_p%0d: addr=%0d, expected 7", pass, imem_addr);
      end
      @(negedge clk);
      checks++;
      if (imem_addr !== ((pass == 1) ? 10'd20 : 10'd8)) begin
        errors++;
        $display("[TB] FAIL cjump_next_p%0d: addr=%0d, expected %0d", pass, imem_addr,
                 (pass == 1) ? 20 : 8);
      end
      cond_true = 1'b0;
    end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset();
    do_start();
    repeat (5) @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({imem_addr, valid} !== {10'd5, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: addr=%0d v=%b, expected addr=5 v=0", i, imem_addr, valid);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({imem_addr, valid} !== {10'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL stall_release: addr=%0d v=%b, expected addr=5 v=1", imem_addr, valid);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd6) begin
      errors++;
      $display("[TB] FAIL stall_resume: addr=%0d, expected 6", imem_addr);
    end
  endtask

  task automatic test_halt_and_overflow();
    fill_mem();
    mem[9] = {4'hF, 5'd0};
    do_reset();
    do_start();
    repeat (10) @(negedge clk);
    checks++;
    if ({imem_addr, done, valid} !== {10'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL halt_op: addr=%0d d=%b v=%b, expected addr=9 d=1 v=0", imem_addr, done, valid);
    end
    @(negedge clk);
    checks++;
    if ({imem_addr, done} !== {10'd9, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_hold: addr=%0d d=%b, expected addr=9 d=1", imem_addr, done);
    end
    // Restart from HALT; word 0 now jumps to lut[31] = 1023.
    mem[0] = {4'h8, 5'd31};
    do_start();
    checks++;
    if ({imem_addr, done, valid} !== {10'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_restart: addr=%0d d=%b v=%b, expected addr=0 d=0 v=1", imem_addr, done, valid);
    end
    @(negedge clk);
    checks++;
    if ({imem_addr, pc_ovf} !== {10'd1023, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reach_top: addr=%0d o=%b, expected addr=1023 o=0", imem_addr, pc_ovf);
    end
    @(negedge clk);
    checks++;
    if ({imem_addr, done, pc_ovf} !== {10'd1023, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_halt: addr=%0d d=%b o=%b, expected addr=1023 d=1 o=1", imem_addr, done, pc_ovf);
    end
    do_start();
    checks++;
    if ({imem_addr, done, pc_ovf} !== {10'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_clear: addr=%0d d=%b o=%b, expected addr=0 d=0 o=0", imem_addr, done, pc_ovf);
    end
  endtask

  task automatic test_jump_at_top();
    fill_mem();
    mem[0]    = {4'h8, 5'd31};
    mem[1023] = {4'h8, 5'd2};
    do_reset();
    do_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_addr, done, pc_ovf} !== {10'd40, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL jump_at_top: addr=%0d d=%b o=%b, expected addr=40 d=0 o=0", imem_addr, done, pc_ovf);
    end
  endtask

  task automatic test_async_reset();
    fill_mem();
    do_reset();
    do_start();
    repeat (12) @(negedge clk);
    checks++;
    if (imem_addr !== 10'd12) begin
      errors++;
      $display("[TB] FAIL pre_reset_pc: addr=%0d, expected 12", imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_addr, valid, done, pc_ovf} !== {10'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL async_reset: addr=%0d v=%b d=%b o=%b, expected addr=0 v=0 d=0 o=0",
               imem_addr, valid, done, pc_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_addr, valid} !== {10'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: addr=%0d v=%b, expected addr=0 v=0", imem_addr, valid);
    end
    do_start();
    @(negedge clk);
    checks++;
    if ({imem_addr, valid} !== {10'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL post_reset_run: addr=%0d v=%b, expected addr=1 v=1", imem_addr, valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    cond_true = 1'b0;
    fill_mem();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_uncond_jump();
    test_cond_jump();
    test_stall();
    test_halt_and_overflow();
    test_jump_at_top();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
